// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between the CPU and a DMA engine.
// DMA has fixed priority, with a bounded run length while the CPU is waiting.
module mem_arbiter #(
   parameter int unsigned DMA_MAX_RUN = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [1:0]  cpu_width,
   input  logic        cpu_read,
   input  logic        cpu_write,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ok,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   input  logic [1:0]  dma_width,
   input  logic        dma_read,
   input  logic        dma_write,
   output logic [31:0] dma_rdata,
   output logic        dma_ok,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_width,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ok,
   output logic [1:0]  owner
);

   localparam int unsigned RUN_W = (DMA_MAX_RUN > 0) ? $clog2(DMA_MAX_RUN + 1) : 1;
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DMA_MAX_RUN);
   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_CPU  = 2'b01;
   localparam logic [1:0] OWN_DMA  = 2'b10;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nx;
   logic [RUN_W-1:0] run_cnt, run_cnt_nx;
   logic [31:0]      mem_addr_nx, mem_wdata_nx, cpu_rdata_nx, dma_rdata_nx;
   logic [1:0]       mem_width_nx, owner_nx;
   logic             mem_read_nx, mem_write_nx, cpu_ok_nx, dma_ok_nx;
   logic             cpu_req, dma_req, run_full, cpu_win;

   assign cpu_req  = cpu_read | cpu_write;
   assign dma_req  = dma_read | dma_write;
   assign run_full = (DMA_MAX_RUN != 0) && (run_cnt == RUN_MAX);
   assign cpu_win  = cpu_req && (!dma_req || run_full);

   // State and output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         run_cnt   <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_width <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         cpu_rdata <= '0;
         dma_rdata <= '0;
         cpu_ok    <= 1'b0;
         dma_ok    <= 1'b0;
         owner     <= OWN_NONE;
      end else begin
         state     <= state_nx;
         run_cnt   <= run_cnt_nx;
         mem_addr  <= mem_addr_nx;
         mem_wdata <= mem_wdata_nx;
         mem_width <= mem_width_nx;
         mem_read  <= mem_read_nx;
         mem_write <= mem_write_nx;
         cpu_rdata <= cpu_rdata_nx;
         dma_rdata <= dma_rdata_nx;
         cpu_ok    <= cpu_ok_nx;
         dma_ok    <= dma_ok_nx;
         owner     <= owner_nx;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nx     = state;
      run_cnt_nx   = run_cnt;
      mem_addr_nx  = mem_addr;
      mem_wdata_nx = mem_wdata;
      mem_width_nx = mem_width;
      mem_read_nx  = mem_read;
      mem_write_nx = mem_write;
      cpu_rdata_nx = cpu_rdata;
      dma_rdata_nx = dma_rdata;
      cpu_ok_nx    = 1'b0;
      dma_ok_nx    = 1'b0;
      owner_nx     = owner;

      unique case (state)
         IDLE: begin
            if (!cpu_req) run_cnt_nx = '0;
            if (cpu_win) begin
               state_nx     = BUSY;
               run_cnt_nx   = '0;
               mem_addr_nx  = cpu_addr;
               mem_wdata_nx = cpu_wdata;
               mem_width_nx = cpu_width;
               mem_write_nx = cpu_write;
               mem_read_nx  = !cpu_write;
               owner_nx     = OWN_CPU;
            end else if (dma_req) begin
               state_nx     = BUSY;
               if (cpu_req && !run_full) run_cnt_nx = run_cnt + 1'b1;
               mem_addr_nx  = dma_addr;
               mem_wdata_nx = dma_wdata;
               mem_width_nx = dma_width;
               mem_write_nx = dma_write;
               mem_read_nx  = !dma_write;
               owner_nx     = OWN_DMA;
            end
         end
         BUSY: begin
            if (mem_ok) begin
               state_nx     = DONE;
               mem_read_nx  = 1'b0;
               mem_write_nx = 1'b0;
               if (owner == OWN_CPU) begin
                  cpu_ok_nx = 1'b1;
                  if (mem_read) cpu_rdata_nx = mem_rdata;
               end else begin
                  dma_ok_nx = 1'b1;
                  if (mem_read) dma_rdata_nx = mem_rdata;
               end
            end
         end
         DONE: begin
            state_nx = IDLE;
            owner_nx = OWN_NONE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule
